if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch front end for the `cpu` core. Holds the PC, drives the combinational instruction ROM through the `rom_addr_o`/`rom_ce_o`/`rom_data_i` interface and buffers fetched {pc, inst} pairs in a small FIFO. The decode stage drains the FIFO through a valid/ready handshake. A branch redirect from execute flushes the FIFO and restarts fetch at the target.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, default 0: PC value after reset; word-aligned.

Ports:
- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rst_in` in 1: reset; **synchronous, active-low**.
- `rom_data_i` in `InstLen`: instruction word for `rom_addr_o`, valid in the same cycle (combinational ROM).
- `rom_addr_o` out `AddrLen`: current PC.
- `rom_ce_o` out 1: ROM enable; a fetch occurs in every cycle it is high.
- `br_valid_i` in 1: redirect request from execute.
- `br_target_i` in `AddrLen`: redirect target.
- `id_ready_i` in 1: decode accepts the head entry this cycle.
- `if_valid_o` out 1: head entry valid.
- `if_pc_o` out `AddrLen`: PC of the head entry.
- `if_inst_o` out `InstLen`: instruction of the head entry.

## Operation
- State:
  - `pc` (`AddrLen`)
  - FIFO storage of DEPTH × {pc, inst}
  - read pointer and write pointer, each log2(DEPTH) bits
  - `count`, log2(DEPTH)+1 bits
- `rom_addr_o` = `pc`.
- `rom_ce_o` = `rst_in` & !`br_valid_i` & (`count` != DEPTH).
- Fetch (`rom_ce_o`=1):
  - push {`pc`, `rom_data_i`} at the write pointer.
  - `pc` <= `pc` + 4, with modulo-2^`AddrLen` wrap (0xFFFFFFFC → 0).
- Pop:
  - `if_valid_o` = `rst_in` & (`count` != 0) & !`br_valid_i`.
  - `if_pc_o` and `if_inst_o` come from the head entry. Their value is don't-care when `if_valid_o`=0.
  - Pop when `if_valid_o` & `id_ready_i`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full FIFO: no fetch, even if a pop occurs in the same cycle. Fetch resumes the following cycle.
- Empty FIFO: `if_valid_o`=0; `id_ready_i` is ignored.
- Redirect (`br_valid_i`=1) has priority over push and pop:
  - `count` <= 0 and both pointers <= 0.
  - `pc` <= {`br_target_i`[`AddrLen`-1:2], 2'b00}; the low two bits are ignored.
  - No fetch and no pop occur in that cycle.
- Reset (`rst_in`=0 at a clock edge):
  - `pc` <= `RESET_PC`, `count` <= 0, pointers <= 0.
  - While `rst_in`=0, `rom_ce_o`=0 and `if_valid_o`=0 combinationally.
  - Asserting reset mid-stream discards all buffered entries.
- Pointer wrap is natural modulo DEPTH.

## Timing
- Fetch-to-valid latency: 1 cycle. An instruction fetched in cycle N is presented with `if_valid_o`=1 in cycle N+1.
- After reset release: `RESET_PC` is fetched in the first cycle with `rst_in`=1, and `if_valid_o` rises in the second.
- Redirect penalty: redirect in cycle N; the target is fetched in N+1; the target is presented in N+2.
- Throughput with `id_ready_i` held at 1: one instruction per cycle; `count` settles at 1.
- With `id_ready_i` held at 0: the FIFO fills after DEPTH fetches; `rom_ce_o` drops and `pc` holds.
- Reset values of outputs (first cycle after a reset edge with `rst_in` back at 1):
  - `rom_addr_o`=`RESET_PC`.
  - `if_valid_o`=0, because the FIFO is empty.
  - `if_pc_o` and `if_inst_o` read entry 0 and are don't-care.

## Structure
- Shared header holds the `AddrLen` (32) and `InstLen` (32) macros, plus new `InstStep` (4) and `ZeroWord`. `RESET_PC` defaults to `ZeroWord`.
- Sub-module `inst_fifo` (parameters DEPTH and width `AddrLen`+`InstLen`). Ports: `push`, `pop`, `flush`, `full`, `empty`, `din`, `dout`.
- `if_fetch` itself holds the PC and control logic only.
- `if_fetch` replaces the PC logic inside `cpu`. It connects to `rom0` through the existing `rom_addr_o`/`rom_ce_o`/`rom_data_i` nets.

## Test plan
- **Reset and free run:** ROM word at address k = 0x1000+k; release reset with `id_ready_i`=1. Required: `if_pc_o` = 0, 4, 8, … on consecutive cycles from cycle 2, with `if_inst_o` = 0x1000, 0x1001, …
- **Backpressure:** hold `id_ready_i`=0 for 10 cycles. Required: exactly 4 fetches, then `rom_ce_o`=0 and `rom_addr_o`=0x10. On release, pcs 0..0xC drain in order, then 0x10 appears.
- **Redirect:** pulse `br_valid_i` with `br_target_i`=0x203 while 3 entries are buffered. Required: `if_valid_o`=0 in that cycle and the next; then `if_pc_o`=0x200. No stale entry ever appears.
- **Simultaneous events:** a redirect in the same cycle as pop and push on a full FIFO. Required: the redirect wins and `count`=0 afterwards.
- **PC wrap:** redirect to 0xFFFFFFF8. Required: pcs presented are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- **Reset mid-operation:** drive `rst_in`=0 for one edge with 2 entries buffered. Required: `if_valid_o`=0 immediately, the FIFO is empty, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
//   Shared widths and helpers for the instruction-fetch front end.
//   AddrLen / InstLen : address and instruction word widths
//   InstStep          : byte distance between consecutive instructions
//   ZeroWord          : all-zero address, the default reset PC
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int unsigned AddrLen = 32;
    localparam int unsigned InstLen = 32;
    localparam int unsigned FetchW  = AddrLen + InstLen;

    localparam logic [AddrLen-1:0] InstStep = AddrLen'(4);
    localparam logic [AddrLen-1:0] ZeroWord = '0;

    // Word-align an address by clearing its two byte-offset bits.
    function automatic logic [AddrLen-1:0] align_word(input logic [AddrLen-1:0] addr);
        return addr & ~AddrLen'(3);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// -----------------------------------------------------------------------------
// if_fetch_if
//   Bundles the fetch unit's ROM, redirect and decode-handshake signals.
//   master : the fetch unit (drives ROM address/enable and the decode side)
//   slave  : the environment (ROM, execute redirect, decode stage)
// -----------------------------------------------------------------------------
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic [AddrLen-1:0] rom_addr_o;
    logic               rom_ce_o;
    logic [InstLen-1:0] rom_data_i;
    logic               br_valid_i;
    logic [AddrLen-1:0] br_target_i;
    logic               id_ready_i;
    logic               if_valid_o;
    logic [AddrLen-1:0] if_pc_o;
    logic [InstLen-1:0] if_inst_o;

    modport master (
        output rom_addr_o, rom_ce_o, if_valid_o, if_pc_o, if_inst_o,
        input  rom_data_i, br_valid_i, br_target_i, id_ready_i
    );

    modport slave (
        input  rom_addr_o, rom_ce_o, if_valid_o, if_pc_o, if_inst_o,
        output rom_data_i, br_valid_i, br_target_i, id_ready_i
    );

endinterface

// File: rtl/if_fetch_inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
//   Small synchronous FIFO holding fetched {pc, inst} pairs.
//   clk_in, rst_in : clock, synchronous active-low reset (control only)
//   push, pop      : enqueue din / dequeue head (ignored when full / empty)
//   flush          : drop every entry; takes priority over push and pop
//   full, empty    : occupancy flags
//   din, dout      : write data, head entry (don't-care when empty)
// -----------------------------------------------------------------------------
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CntW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_in) begin
        if (!rst_in || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_in) begin
        if (rst_in && !flush && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch front end: holds the PC, fetches from a combinational
//   ROM every cycle the buffer has room, and presents buffered {pc, inst}
//   pairs to decode through a valid/ready handshake. A redirect from execute
//   flushes the buffer and restarts fetch at the (word-aligned) target.
//   clk_in : clock
//   rst_in : synchronous active-low reset
//   bus    : if_fetch_if.master
//            rom_addr_o/rom_ce_o/rom_data_i   ROM port (rom_addr_o = pc)
//            br_valid_i/br_target_i           redirect from execute
//            if_valid_o/if_pc_o/if_inst_o     head entry towards decode
//            id_ready_i                       decode accepts the head entry
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [AddrLen-1:0] RESET_PC = ZeroWord
) (
    input  logic         clk_in,
    input  logic         rst_in,
    if_fetch_if.master   bus
);

    logic [AddrLen-1:0] pc;
    logic               full;
    logic               empty;
    logic               fetch;
    logic               valid;
    logic               pop;
    logic [FetchW-1:0]  head;

    // Redirect and reset both suppress fetch and presentation combinationally,
    // so no stale entry leaks out in the redirect cycle itself.
    assign fetch = rst_in & ~bus.br_valid_i & ~full;
    assign valid = rst_in & ~empty & ~bus.br_valid_i;
    assign pop   = valid & bus.id_ready_i;

    assign bus.rom_addr_o = pc;
    assign bus.rom_ce_o   = fetch;
    assign bus.if_valid_o = valid;
    assign bus.if_pc_o    = head[FetchW-1:InstLen];
    assign bus.if_inst_o  = head[InstLen-1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc <= RESET_PC;
        end else if (bus.br_valid_i) begin
            pc <= align_word(bus.br_target_i);
        end else if (fetch) begin
            pc <= pc + InstStep;
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FetchW)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (fetch),
        .pop    (pop),
        .flush  (bus.br_valid_i),
        .full   (full),
        .empty  (empty),
        .din    ({pc, bus.rom_data_i}),
        .dout   (head)
    );

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch. A queue-based model of the fetch buffer is
//   compared against the DUT on every falling edge, and directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    if_fetch_if bus ();

    if_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ROM word at word index k is 0x1000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    always_comb bus.rom_data_i = rom_word(bus.rom_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    ent_t        q[$];
    logic [31:0] mpc = 32'h0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_ce;
            logic exp_valid;
            exp_ce    = rst && !bus.br_valid_i && (q.size() != DEPTH);
            exp_valid = rst && (q.size() != 0) && !bus.br_valid_i;
            check("m_rom_ce",   32'(bus.rom_ce_o),   32'(exp_ce));
            check("m_if_valid", 32'(bus.if_valid_o), 32'(exp_valid));
            check("m_rom_addr", bus.rom_addr_o, mpc);
            if (exp_valid) begin
                check("m_if_pc",   bus.if_pc_o,   q[0].pc);
                check("m_if_inst", bus.if_inst_o, q[0].inst);
            end
            if (!rst) begin
                q.delete();
                mpc = 32'h0;
            end else if (bus.br_valid_i) begin
                q.delete();
                mpc = {bus.br_target_i[31:2], 2'b00};
            end else begin
                if (exp_valid && bus.id_ready_i) void'(q.pop_front());
                if (exp_ce) begin
                    q.push_back('{pc: mpc, inst: rom_word(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    logic [31:0] drain_exp [5];
    int          nfetch;

    initial begin
        drain_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        bus.br_valid_i  = 1'b0;
        bus.br_target_i = 32'h0;
        bus.id_ready_i  = 1'b1;
        rst = 1'b0;

        // Reset and free run
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_addr",  bus.rom_addr_o, 32'h0);
        check("rst_ce",    32'(bus.rom_ce_o), 32'd1);
        check("rst_valid", 32'(bus.if_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("run_valid", 32'(bus.if_valid_o), 32'd1);
            check("run_pc",    bus.if_pc_o, 32'(4 * i));
            check("run_inst",  bus.if_inst_o, 32'h1000 + 32'(i));
        end
        repeat (4) step();

        // Backpressure from an empty buffer
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.id_ready_i = 1'b0;
        nfetch = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rom_ce_o) nfetch++;
            step();
        end
        @(negedge clk);
        check("bp_fetches", 32'(nfetch), 32'd4);
        check("bp_ce",      32'(bus.rom_ce_o), 32'd0);
        check("bp_addr",    bus.rom_addr_o, 32'h10);
        check("bp_head_pc", bus.if_pc_o, 32'h0);
        step();
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(bus.if_valid_o), 32'd1);
            check("drain_pc",    bus.if_pc_o, drain_exp[i]);
            step();
        end

        // Redirect with three entries buffered
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.id_ready_i = 1'b0;
        repeat (3) step();
        bus.br_valid_i  = 1'b1;
        bus.br_target_i = 32'h203;
        bus.id_ready_i  = 1'b1;
        @(negedge clk);
        check("br_valid_n", 32'(bus.if_valid_o), 32'd0);
        check("br_ce_n",    32'(bus.rom_ce_o), 32'd0);
        step();
        bus.br_valid_i = 1'b0;
        @(negedge clk);
        check("br_valid_n1", 32'(bus.if_valid_o), 32'd0);
        check("br_addr_n1",  bus.rom_addr_o, 32'h200);
        step();
        @(negedge clk);
        check("br_valid_n2", 32'(bus.if_valid_o), 32'd1);
        check("br_pc_n2",    bus.if_pc_o, 32'h200);
        check("br_inst_n2",  bus.if_inst_o, 32'h1080);
        step();

        // Redirect coinciding with pop on a full buffer
        bus.id_ready_i = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check("sim_full_ce", 32'(bus.rom_ce_o), 32'd0);
        step();
        bus.br_valid_i  = 1'b1;
        bus.br_target_i = 32'h40;
        bus.id_ready_i  = 1'b1;
        @(negedge clk);
        check("sim_valid_n", 32'(bus.if_valid_o), 32'd0);
        step();
        bus.br_valid_i = 1'b0;
        @(negedge clk);
        check("sim_empty",  32'(bus.if_valid_o), 32'd0);
        check("sim_addr",   bus.rom_addr_o, 32'h40);
        step();
        @(negedge clk);
        check("sim_pc", bus.if_pc_o, 32'h40);

        // PC wrap
        step();
        bus.br_valid_i  = 1'b1;
        bus.br_target_i = 32'hFFFF_FFF8;
        step();
        bus.br_valid_i = 1'b0;
        @(negedge clk);
        check("wrap_gap", 32'(bus.if_valid_o), 32'd0);
        step();
        @(negedge clk);
        check("wrap_pc0", bus.if_pc_o, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check("wrap_pc1", bus.if_pc_o, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("wrap_pc2", bus.if_pc_o, 32'h0);

        // Reset mid-operation with two entries buffered
        step();
        bus.br_valid_i  = 1'b1;
        bus.br_target_i = 32'h100;
        bus.id_ready_i  = 1'b0;
        step();
        bus.br_valid_i = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(bus.if_valid_o), 32'd0);
        check("mrst_ce",    32'(bus.rom_ce_o), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mrst_empty", 32'(bus.if_valid_o), 32'd0);
        check("mrst_addr",  bus.rom_addr_o, 32'h0);
        step();
        @(negedge clk);
        check("mrst_restart_valid", 32'(bus.if_valid_o), 32'd1);
        check("mrst_restart_pc",    bus.if_pc_o, 32'h0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
